reaction_round_ctrl: RTL and testbench

//   Round controller for the reaction timer. Consumes the 4-bit pseudorandom nibble from the LFSR.

---
 rtl/reaction_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round controller: random pre-go delay, GO LED, ms reaction count.
// Latency: start -> busy next cycle; press at edge M -> done pulse and rt_ms valid in the cycle after M.
// Optional feature macro EARLY_PRESS_EN: a press during the pre-go wait ends the round as a cheat.
module reaction_round_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int MIN_MS  = 1000,
  parameter int STEP_MS = 250,
  parameter int MAX_MS  = 9999,
  parameter int RT_W    = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            button,
  input  logic [3:0]      rnd,
  output logic            led_go,
  output logic            busy,
  output logic            done,
  output logic            cheat,
  output logic            timeout,
  output logic [RT_W-1:0] rt_ms
);

  localparam int TICK = CLK_HZ / 1000;
  localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int DMAX = MIN_MS + 15 * STEP_MS;
  localparam int CMAX = (DMAX > MAX_MS) ? DMAX : MAX_MS;
  // Counter is never narrower than 16 bits so delay_ms is computed without truncation.
  localparam int CW   = ($clog2(CMAX + 1) < 16) ? 16 : $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GO, S_SHOW} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   ms_q, ms_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic            btn_q;
  logic            done_q, done_d;
  logic            cheat_q, cheat_d;
  logic            timeout_q, timeout_d;

  logic            press;
  logic            tick;
  logic [CW-1:0]   delay_ms;
  logic [CW-1:0]   ms_inc;

  // Rising edge of the button only, so a press held into GO never counts.
  assign press    = button & ~btn_q;
  assign tick     = (presc_q == PW'(TICK - 1));
  assign delay_ms = CW'(MIN_MS) + CW'(rnd_q) * CW'(STEP_MS);
  assign ms_inc   = ms_q + CW'(1);

  // Next-state, counters and result capture.
  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    ms_d      = ms_q;
    rnd_d     = rnd_q;
    rt_d      = rt_q;
    done_d    = 1'b0;
    cheat_d   = cheat_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (start) begin
          rnd_d     = rnd;
          cheat_d   = 1'b0;
          timeout_d = 1'b0;
          ms_d      = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef EARLY_PRESS_EN
        if (press) begin
          cheat_d = 1'b1;
          rt_d    = '0;
          done_d  = 1'b1;
          state_d = S_SHOW;
        end else
`endif
        if (tick) begin
          if (ms_inc == delay_ms) begin
            ms_d    = '0;
            state_d = S_GO;
          end else begin
            ms_d = ms_inc;
          end
        end
      end
      S_GO: begin
        // A press beats a coincident timeout tick and reports the pre-tick count.
        if (press) begin
          rt_d    = RT_W'(ms_q);
          done_d  = 1'b1;
          state_d = S_SHOW;
        end else if (tick) begin
          if (ms_inc == CW'(MAX_MS)) begin
            rt_d      = RT_W'(MAX_MS);
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_SHOW;
          end else begin
            ms_d = ms_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Every state entry restarts the ms prescaler so the first tick lands TICK cycles later.
    if (state_d != state_q) presc_d = '0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ms_q      <= '0;
      rnd_q     <= '0;
      rt_q      <= '0;
      btn_q     <= 1'b0;
      done_q    <= 1'b0;
      cheat_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      rnd_q     <= rnd_d;
      rt_q      <= rt_d;
      btn_q     <= button;
      done_q    <= done_d;
      cheat_q   <= cheat_d;
      timeout_q <= timeout_d;
    end
  end

  assign led_go  = (state_q == S_GO);
  assign busy    = (state_q == S_WAIT) || (state_q == S_GO);
  assign done    = done_q;
  assign cheat   = cheat_q;
  assign timeout = timeout_q;
  assign rt_ms   = rt_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with TICK=4, MIN_MS=2, STEP_MS=1, MAX_MS=20.
// Table of full rounds plus hand sequences for held button, early press, start-ignore and reset.
module tb_reaction_round_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, button;
  logic [3:0]  rnd;
  logic        led_go, busy, done, cheat, timeout;
  logic [13:0] rt_ms;

  int checks   = 0;
  int failures = 0;

  reaction_round_ctrl #(
    .CLK_HZ(4000), .MIN_MS(2), .STEP_MS(1), .MAX_MS(20), .RT_W(14)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .button(button), .rnd(rnd),
    .led_go(led_go), .busy(busy), .done(done), .cheat(cheat),
    .timeout(timeout), .rt_ms(rt_ms)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rnd;
    int         go_cyc;    // edges from start-accept edge to GO entry
    int         press;     // edges after GO entry at which press is sampled; 0 = never press
    int         done_cyc;  // edges after GO entry at which the result is latched
    int         rt;
    int         to;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [3:0] r);
    rnd   = r;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_clr_timeout", timeout, 0);
    check("start_clr_cheat", cheat, 0);
  endtask

  task automatic wait_go(output int c, output bit busy_all);
    c = 0;
    busy_all = 1'b1;
    while (!led_go && c < 400) begin
      if (!busy) busy_all = 1'b0;
      step();
      c++;
    end
  endtask

  initial begin
    int  c, n;
    bit  ok, seen;

    vecs[0] = '{4'd5,  28, 13, 13,  3, 0};  // normal press at 3 ms + 1 cycle
    vecs[1] = '{4'd0,   8,  0, 80, 20, 1};  // no press: timeout at MAX_MS
    vecs[2] = '{4'd15, 68,  1,  1,  0, 0};  // longest delay, immediate press
    vecs[3] = '{4'd3,  20, 12, 12,  2, 0};  // press coincides with a tick
    vecs[4] = '{4'd1,  12, 80, 80, 19, 0};  // press coincides with timeout tick
    vecs[5] = '{4'd2,  16, 41, 41, 10, 0};

    reset = 1'b1; start = 1'b0; button = 1'b0; rnd = 4'd0;
    step(); step();
    check("rst_led_go", led_go, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cheat", cheat, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rt_ms", rt_ms, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      start_round(vecs[i].rnd);
      wait_go(c, ok);
      check("go_delay", c, vecs[i].go_cyc);
      check("busy_in_wait", ok, 1);
      n = 0;
      if (vecs[i].press > 0) begin
        repeat (vecs[i].press - 1) step();
        button = 1'b1;
        step();
        n = vecs[i].press;
      end else begin
        while (!done && n < 200) begin
          step();
          n++;
        end
      end
      check("done_cyc", n, vecs[i].done_cyc);
      check("done_pulse", done, 1);
      check("led_off", led_go, 0);
      check("busy_off", busy, 0);
      check("rt_ms", rt_ms, vecs[i].rt);
      check("timeout", timeout, vecs[i].to);
      button = 1'b0;
      step();
      check("done_one_cycle", done, 0);
      check("rt_held", rt_ms, vecs[i].rt);
    end

    // Button held across GO never counts; a fresh press at 4 ms does.
    button = 1'b1;
    start_round(4'd0);
    wait_go(c, ok);
    check("held_go_delay", c, 8);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (done) seen = 1'b1;
    end
    check("held_no_done", seen, 0);
    check("held_led_on", led_go, 1);
    button = 1'b0;
    repeat (6) step();
    button = 1'b1;
    step();
    check("held_done", done, 1);
    check("held_rt", rt_ms, 4);
    button = 1'b0;
    step();

    // Press during the pre-go wait.
    start_round(4'd5);
    repeat (5) step();
    button = 1'b1;
    step();
    button = 1'b0;
`ifdef EARLY_PRESS_EN
    check("early_done", done, 1);
    check("early_cheat", cheat, 1);
    check("early_rt", rt_ms, 0);
    check("early_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (led_go) seen = 1'b1;
    end
    check("early_no_led", seen, 0);
    check("early_cheat_sticky", cheat, 1);
`else
    check("early_ignored_done", done, 0);
    check("early_ignored_cheat", cheat, 0);
    check("early_ignored_busy", busy, 1);
    wait_go(c, ok);
    check("early_go_delay", c, 22);
    repeat (4) step();
    button = 1'b1;
    step();
    check("early_later_done", done, 1);
    check("early_later_rt", rt_ms, 1);
    button = 1'b0;
    step();
`endif

    // Start ignored in WAIT and GO; reset mid-GO clears everything.
    start_round(4'd0);
    repeat (3) step();
    rnd   = 4'd15;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_go(c, ok);
    check("wait_start_ignored", c, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    check("go_start_ignored", led_go, 1);
    repeat (5) step();
    reset = 1'b1;
    step();
    check("midrst_led_go", led_go, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rt", rt_ms, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_cheat", cheat, 0);
    reset = 1'b0;
    step();
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
